// File: rtl/writeback_regfile.sv
// Writeback stage: commits results into the 8x16 register file and serves the two decode
// read ports with same-cycle write bypass. Also tracks halt and counts retired instructions.

module writeback_regfile_entry #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         we_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] q_q;

    always_ff @(posedge clk) begin
        if (!rst_n)    q_q <= '0;
        else if (we_i) q_q <= d_i;
    end

    assign q_o = q_q;
endmodule

module writeback_regfile #(
    parameter int NREGS = 8,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             bubble_in,
    input  logic [2:0]       opcode_in,
    input  logic [2:0]       tgt_in,
    input  logic [15:0]      result_in,
    input  logic             halt_in,
    input  logic [2:0]       ra_addr,
    input  logic [2:0]       rb_addr,
    output logic [15:0]      ra_data,
    output logic [15:0]      rb_data,
    output logic             fwd_valid,
    output logic [2:0]       fwd_tgt,
    output logic [15:0]      fwd_val,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);
    localparam int DW     = 16;
    localparam int AW     = 3;
    localparam int NPORTS = 2;

    localparam logic [2:0] OP_SW  = 3'b100;
    localparam logic [2:0] OP_BEQ = 3'b110;

    typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

    state_t            state_q;
    logic              fwd_valid_q;
    logic [AW-1:0]     fwd_tgt_q;
    logic [DW-1:0]     fwd_val_q;
    logic [CNT_W-1:0]  retired_q;

    logic              commit;
    logic              writes_reg;
    logic              we;

    logic [NREGS-1:0][DW-1:0]  regs;
    logic [NPORTS-1:0][AW-1:0] rd_addr;
    logic [NPORTS-1:0][DW-1:0] rd_data;

    assign commit     = (state_q == RUN) && !stall && !bubble_in;
    assign writes_reg = (opcode_in != OP_SW) && (opcode_in != OP_BEQ);
    assign we         = commit && writes_reg && !halt_in && (tgt_in != '0);

    // r0 is hardwired zero; only r1..r(NREGS-1) have storage.
    assign regs[0] = '0;

    genvar gi;
    generate
        for (gi = 1; gi < NREGS; gi++) begin : g_reg
            writeback_regfile_entry #(.W(DW)) u_entry (
                .clk   (clk),
                .rst_n (rst_n),
                .we_i  (we && (tgt_in == AW'(gi))),
                .d_i   (result_in),
                .q_o   (regs[gi])
            );
        end
    endgenerate

    assign rd_addr[0] = ra_addr;
    assign rd_addr[1] = rb_addr;

    // Bypass lets decode see a value in the same cycle it commits.
    generate
        for (gi = 0; gi < NPORTS; gi++) begin : g_rd
            always_comb begin
                rd_data[gi] = regs[rd_addr[gi]];
                if (rd_addr[gi] == '0)
                    rd_data[gi] = '0;
                else if (we && (rd_addr[gi] == tgt_in))
                    rd_data[gi] = result_in;
            end
        end
    endgenerate

    assign ra_data = rd_data[0];
    assign rb_data = rd_data[1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= RUN;
            fwd_valid_q <= 1'b0;
            fwd_tgt_q   <= '0;
            fwd_val_q   <= '0;
            retired_q   <= '0;
        end else if (!stall) begin
            fwd_valid_q <= we;
            if (we) begin
                fwd_tgt_q <= tgt_in;
                fwd_val_q <= result_in;
            end
            if (commit) retired_q <= retired_q + CNT_W'(1);
            if (commit && halt_in) state_q <= HALTED;
        end
    end

    assign fwd_valid = fwd_valid_q;
    assign fwd_tgt   = fwd_tgt_q;
    assign fwd_val   = fwd_val_q;
    assign halted    = (state_q == HALTED);
    assign retired   = retired_q;
endmodule

// File: tb/tb_writeback_regfile.sv
// Random and directed stimulus for writeback_regfile against an architectural register model.

module tb_writeback_regfile;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n, stall, bubble_in, halt_in;
    logic [2:0]       opcode_in, tgt_in, ra_addr, rb_addr;
    logic [15:0]      result_in;
    logic [15:0]      ra_data, rb_data;
    logic             fwd_valid, halted;
    logic [2:0]       fwd_tgt;
    logic [15:0]      fwd_val;
    logic [CNT_W-1:0] retired;

    writeback_regfile #(.NREGS(8), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .bubble_in(bubble_in),
        .opcode_in(opcode_in), .tgt_in(tgt_in), .result_in(result_in), .halt_in(halt_in),
        .ra_addr(ra_addr), .rb_addr(rb_addr), .ra_data(ra_data), .rb_data(rb_data),
        .fwd_valid(fwd_valid), .fwd_tgt(fwd_tgt), .fwd_val(fwd_val),
        .halted(halted), .retired(retired)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;

    logic [15:0]      m_regs [8];
    bit               m_halt;
    logic [CNT_W-1:0] m_ret;
    bit               m_fv;
    logic [2:0]       m_ft;
    logic [15:0]      m_fval;
    logic [15:0]      obs_ra, obs_rb;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] m_read(input logic [2:0] a, input bit w,
                                           input logic [2:0] t, input logic [15:0] r);
        if (a == 0) return 16'h0;
        if (w && a == t) return r;
        return m_regs[a];
    endfunction

    task automatic m_reset();
        foreach (m_regs[i]) m_regs[i] = 16'h0;
        m_halt = 0; m_ret = '0; m_fv = 0; m_ft = 3'd0; m_fval = 16'h0;
    endtask

    // One clock: drive, check the combinational reads, clock, update model, check state.
    task automatic step(input bit rst, input bit st, input bit bub, input logic [2:0] op,
                        input logic [2:0] t, input logic [15:0] r, input bit h,
                        input logic [2:0] a, input logic [2:0] b);
        bit commit, w;
        @(negedge clk);
        rst_n = !rst; stall = st; bubble_in = bub; opcode_in = op;
        tgt_in = t; result_in = r; halt_in = h; ra_addr = a; rb_addr = b;
        #1;
        commit = !m_halt && !st && !bub;
        w = commit && op != 3'b100 && op != 3'b110 && !h && t != 0;
        obs_ra = ra_data; obs_rb = rb_data;
        chk("ra_data", ra_data, m_read(a, w, t, r));
        chk("rb_data", rb_data, m_read(b, w, t, r));
        @(posedge clk);
        if (rst) m_reset();
        else if (!st) begin
            m_fv = w;
            if (w) begin m_ft = t; m_fval = r; m_regs[t] = r; end
            if (commit) m_ret = m_ret + 1'b1;
            if (commit && h) m_halt = 1;
        end
        #1;
        chk("fwd_valid", fwd_valid, m_fv);
        chk("fwd_tgt", fwd_tgt, m_ft);
        chk("fwd_val", fwd_val, m_fval);
        chk("halted", halted, m_halt);
        chk("retired", retired, m_ret);
    endtask

    initial begin
        rst_n = 0; stall = 0; bubble_in = 1; halt_in = 0; opcode_in = 0;
        tgt_in = 0; result_in = 0; ra_addr = 0; rb_addr = 0;
        m_reset();

        step(1, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("rst_retired", retired, 0);
        chk("rst_halted", halted, 0);

        // 1: write r3 with bypass, then visible from storage
        step(0, 0, 0, 3'b000, 3, 16'hBEEF, 0, 3, 3);
        chk("t1_bypass", obs_ra, 16'hBEEF);
        chk("t1_fwd_valid", fwd_valid, 1);
        chk("t1_fwd_tgt", fwd_tgt, 3);
        chk("t1_retired", retired, 1);
        step(0, 0, 1, 0, 0, 0, 0, 3, 0);
        chk("t1_stored", obs_ra, 16'hBEEF);

        // 2: write to r0 is dropped but retires
        step(0, 0, 0, 3'b000, 0, 16'h1234, 0, 0, 0);
        chk("t2_r0", obs_ra, 0);
        chk("t2_fwd_valid", fwd_valid, 0);
        chk("t2_retired", retired, 2);

        // 3: sw and beq do not write
        step(0, 0, 0, 3'b000, 5, 16'h0055, 0, 0, 0);
        step(0, 0, 0, 3'b100, 5, 16'h0007, 0, 5, 0);
        chk("t3_sw_nobyp", obs_ra, 16'h0055);
        step(0, 0, 0, 3'b110, 5, 16'h0009, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 5, 0);
        chk("t3_r5", obs_ra, 16'h0055);
        chk("t3_retired", retired, 5);

        // 5: stall holds everything, then a single commit
        for (int i = 0; i < 3; i++) step(0, 1, 0, 3'b000, 4, 16'h0009, 0, 4, 0);
        chk("t5_stall_r4", obs_ra, 16'h0000);
        chk("t5_stall_ret", retired, 5);
        step(0, 0, 0, 3'b000, 4, 16'h0009, 0, 4, 0);
        chk("t5_commit_ret", retired, 6);
        chk("t5_fwd_val", fwd_val, 16'h0009);

        // 4: halt ignored under bubble, then real halt
        step(0, 0, 1, 3'b000, 2, 16'h00AA, 1, 0, 0);
        chk("t4_bub_halt", halted, 0);
        chk("t4_bub_ret", retired, 6);
        step(0, 0, 0, 3'b000, 2, 16'h00AA, 1, 2, 0);
        chk("t4_halt_nobyp", obs_ra, 16'h0000);
        chk("t4_halted", halted, 1);
        chk("t4_halt_ret", retired, 7);
        chk("t4_fwd_valid", fwd_valid, 0);
        step(0, 0, 0, 3'b000, 2, 16'h00BB, 0, 2, 0);
        step(0, 0, 1, 0, 0, 0, 0, 2, 0);
        chk("t4_r2_frozen", obs_ra, 16'h0000);
        chk("t4_ret_frozen", retired, 7);

        // 6: reset under stall while halted
        step(1, 1, 0, 3'b000, 1, 16'h1111, 0, 0, 0);
        chk("t6_halted", halted, 0);
        chk("t6_retired", retired, 0);
        for (int i = 1; i < 8; i++) begin
            step(0, 1, 0, 0, 0, 0, 0, 3'(i), 3'(i));
            chk("t6_reg_zero", obs_ra, 0);
        end

        // counter wrap
        for (int i = 0; i < (1 << CNT_W) - 1; i++) step(0, 0, 0, 3'b100, 1, 16'h0, 0, 0, 0);
        chk("wrap_max", retired, (1 << CNT_W) - 1);
        step(0, 0, 0, 3'b110, 1, 16'h0, 0, 0, 0);
        chk("wrap_zero", retired, 0);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 59) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 4) == 0, 3'($urandom), 3'($urandom), 16'($urandom),
                 $urandom_range(0, 49) == 0, 3'($urandom), 3'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end
endmodule
